alu_seq: RTL

Parametrised, handshaked successor to the 4-bit datapath ALU. It executes add, subtract, logic, shift and (optionally) multi-cycle unsigned multiply on WIDTH-bit operands. Operands are accepted over a valid/ready input channel; a registered result and flags are returned over a valid/ready output channel. It sits between register-file read and write-back in the CPU datapath.

---
 rtl/alu_pkg.sv | 38 +++
 rtl/alu_mul_seq.sv | 64 ++++++
 rtl/alu_seq.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : alu_pkg                                                    |
// | Description : Shared types for the sequential ALU: opcode encoding, FSM  |
// |               state encoding and the result-flag bundle.                 |
// |               Optional feature macro: ALU_MUL_EN (adds the BUSY state).  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_SHL = 3'd5,
    OP_SHR = 3'd6,
    OP_MUL = 3'd7
  } alu_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
`ifdef ALU_MUL_EN
    ST_BUSY = 2'd1,
`endif
    ST_DONE = 2'd2
  } alu_state_t;

  typedef struct packed {
    logic carry;
    logic zero;
    logic negative;
    logic overflow;
  } alu_flags_t;

endpackage
`default_nettype wire

// File: rtl/alu_mul_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : alu_mul_seq                                                |
// | Description : Unsigned shift-add multiplier, one multiplier bit per      |
// |               cycle. A start pulse loads the operands; done is high in   |
// |               the cycle whose clock edge completes the last partial      |
// |               product, and product already carries the final value then. |
// | Ports       : clock, reset (sync, active-high), start, a, b  -> inputs   |
// |               done, product[2*WIDTH-1:0]                     -> outputs  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module alu_mul_seq #(
  parameter int WIDTH = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int c_CNT_W = $clog2(WIDTH);

  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [c_CNT_W-1:0] r_count;
  logic               r_busy;
  logic [2*WIDTH-1:0] w_sum;

  // Accumulator value after the partial product of the current multiplier bit.
  assign w_sum   = r_acc + (r_mplier[0] ? r_mcand : '0);
  assign done    = r_busy && (r_count == '0);
  assign product = w_sum;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_count  <= '0;
      r_busy   <= 1'b0;
    end else if (start) begin
      r_acc    <= '0;
      r_mcand  <= {{WIDTH{1'b0}}, a};
      r_mplier <= b;
      r_count  <= c_CNT_W'(WIDTH - 1);
      r_busy   <= 1'b1;
    end else if (r_busy) begin
      r_acc    <= w_sum;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      if (r_count == '0) begin
        r_busy <= 1'b0;
      end else begin
        r_count <= r_count - 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/alu_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : alu_seq                                                    |
// | Description : Handshaked WIDTH-bit ALU (add/sub/logic/shift, optional    |
// |               multi-cycle unsigned multiply). Request accepted on        |
// |               in_valid&in_ready; registered result/flags held on         |
// |               out_valid until out_ready.                                 |
// | Ports       : clock, reset (sync, active-high)                           |
// |               in_valid, op[2:0], operand_a, operand_b, out_ready -> in   |
// |               in_ready, out_valid, result, result_hi,                    |
// |               carry, zero, negative, overflow                    -> out  |
// | Config      : define ALU_MUL_EN to implement MUL; otherwise op 7 returns |
// |               a zero result with overflow=1 as an illegal-op marker.     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             carry,
  output logic             zero,
  output logic             negative,
  output logic             overflow
);

  localparam int c_MSB = WIDTH - 1;

  alu_state_t       r_state;
  alu_state_t       w_state_nxt;
  logic             r_bubble;
  logic             w_bubble_nxt;
  logic             w_take;
  logic             w_load_alu;
  logic [WIDTH-1:0] r_result;
  logic [WIDTH-1:0] r_result_hi;
  alu_flags_t       r_flags;

  logic [WIDTH:0]   w_ext;
  logic [WIDTH-1:0] w_alu_res;
  logic [WIDTH-1:0] w_alu_hi;
  alu_flags_t       w_alu_flags;
  logic [SHW-1:0]   w_shamt;

`ifdef ALU_MUL_EN
  logic               w_is_mul;
  logic               w_mul_start;
  logic               w_mul_done;
  logic               w_load_mul;
  logic [2*WIDTH-1:0] w_mul_product;

  assign w_is_mul = (alu_op_t'(op) == OP_MUL);

  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clock   (clock),
    .reset   (reset),
    .start   (w_mul_start),
    .a       (operand_a),
    .b       (operand_b),
    .done    (w_mul_done),
    .product (w_mul_product)
  );
`endif

  // Upper bits of the shift amount are ignored.
  assign w_shamt = operand_b[SHW-1:0];

  // Single-cycle datapath, evaluated on the live inputs and captured at accept.
  always_comb begin
    w_ext       = '0;
    w_alu_res   = '0;
    w_alu_hi    = '0;
    w_alu_flags = '0;
    case (alu_op_t'(op))
      OP_ADD: begin
        w_ext                = {1'b0, operand_a} + {1'b0, operand_b};
        w_alu_res            = w_ext[c_MSB:0];
        w_alu_flags.carry    = w_ext[WIDTH];
        w_alu_flags.overflow = (operand_a[c_MSB] == operand_b[c_MSB]) &&
                               (w_alu_res[c_MSB] != operand_a[c_MSB]);
      end
      OP_SUB: begin
        // Top bit of the extended difference is the borrow.
        w_ext                = {1'b0, operand_a} - {1'b0, operand_b};
        w_alu_res            = w_ext[c_MSB:0];
        w_alu_flags.carry    = w_ext[WIDTH];
        w_alu_flags.overflow = (operand_a[c_MSB] != operand_b[c_MSB]) &&
                               (w_alu_res[c_MSB] != operand_a[c_MSB]);
      end
      OP_AND: w_alu_res = operand_a & operand_b;
      OP_OR:  w_alu_res = operand_a | operand_b;
      OP_XOR: w_alu_res = operand_a ^ operand_b;
      OP_SHL: begin
        // Extra bit above the MSB catches the last bit shifted out (0 for shift 0).
        w_ext             = {1'b0, operand_a} << w_shamt;
        w_alu_res         = w_ext[c_MSB:0];
        w_alu_flags.carry = w_ext[WIDTH];
      end
      OP_SHR: begin
        w_ext             = {operand_a, 1'b0} >> w_shamt;
        w_alu_res         = w_ext[WIDTH:1];
        w_alu_flags.carry = w_ext[0];
      end
`ifndef ALU_MUL_EN
      OP_MUL: w_alu_flags.overflow = 1'b1;
`endif
      default: ;
    endcase
    w_alu_flags.zero     = (w_alu_res == '0);
    w_alu_flags.negative = w_alu_res[c_MSB];
  end

  // Next-state and handshake outputs. r_bubble forces one idle output cycle
  // when a new single-cycle request is taken while a result is being consumed.
  always_comb begin
    w_state_nxt  = r_state;
    w_bubble_nxt = 1'b0;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    w_take       = 1'b0;
    w_load_alu   = 1'b0;
`ifdef ALU_MUL_EN
    w_mul_start  = 1'b0;
    w_load_mul   = 1'b0;
`endif
    case (r_state)
      ST_IDLE: begin
        in_ready = 1'b1;
        w_take   = in_valid;
      end
`ifdef ALU_MUL_EN
      ST_BUSY: begin
        if (w_mul_done) begin
          w_load_mul  = 1'b1;
          w_state_nxt = ST_DONE;
        end
      end
`endif
      ST_DONE: begin
        if (!r_bubble) begin
          out_valid = 1'b1;
          in_ready  = out_ready;
          if (out_ready) begin
            w_state_nxt = ST_IDLE;
            w_take      = in_valid;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    if (w_take) begin
`ifdef ALU_MUL_EN
      if (w_is_mul) begin
        w_mul_start = 1'b1;
        w_state_nxt = ST_BUSY;
      end else
`endif
      begin
        w_load_alu   = 1'b1;
        w_state_nxt  = ST_DONE;
        w_bubble_nxt = (r_state == ST_DONE);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_bubble <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_bubble <= w_bubble_nxt;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_result    <= '0;
      r_result_hi <= '0;
      r_flags     <= '0;
    end else if (w_load_alu) begin
      r_result    <= w_alu_res;
      r_result_hi <= w_alu_hi;
      r_flags     <= w_alu_flags;
    end
`ifdef ALU_MUL_EN
    else if (w_load_mul) begin
      r_result          <= w_mul_product[c_MSB:0];
      r_result_hi       <= w_mul_product[2*WIDTH-1:WIDTH];
      r_flags.carry     <= |w_mul_product[2*WIDTH-1:WIDTH];
      r_flags.zero      <= (w_mul_product == '0);
      r_flags.negative  <= w_mul_product[2*WIDTH-1];
      r_flags.overflow  <= 1'b0;
    end
`endif
  end

  assign result    = r_result;
  assign result_hi = r_result_hi;
  assign carry     = r_flags.carry;
  assign zero      = r_flags.zero;
  assign negative  = r_flags.negative;
  assign overflow  = r_flags.overflow;

endmodule
`default_nettype wire
